vmx_pe_simd: RTL and testbench

// - Parametrised systolic processing element for the vector-matrix engine.
// - Each lane computes data*weight + sum_in, with lane split 1xW, 2x(W/2) or
//   4x(W/4) chosen per cycle.
// - Weight register is double-buffered (shadow + active). Lane arithmetic

---
 rtl/vmx_pkg.sv | 28 ++
 rtl/vmx_sat_mac.sv | 44 ++++
 rtl/vmx_pe_simd.sv | 124 ++++++++++++
 tb/tb_vmx_pe_simd.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vmx_pkg.sv
// Shared constants and helpers for the vector-matrix engine processing elements.
// Mode encodings, lane geometry and load-token field accessors live here.
package vmx_pkg;

  localparam logic [1:0] MODE_X1 = 2'd0;
  localparam logic [1:0] MODE_X2 = 2'd1;
  localparam logic [1:0] MODE_X4 = 2'd2;

  localparam int LANES_X1 = 1;
  localparam int LANES_X2 = 2;
  localparam int LANES_X4 = 4;

  // Token helpers work on a zero-extended copy so one function serves any LC_W.
  localparam int TOK_MAX_W = 32;

  function automatic int lane_w(input int total_w, input int lanes);
    return total_w / lanes;
  endfunction

  function automatic logic tok_armed(input logic [TOK_MAX_W-1:0] tok, input int lc_w);
    return tok[lc_w-1];
  endfunction

  function automatic logic [TOK_MAX_W-1:0] tok_cnt_mask(input int lc_w);
    return (TOK_MAX_W'(1) << (lc_w - 1)) - TOK_MAX_W'(1);
  endfunction

endpackage

// File: rtl/vmx_sat_mac.sv
// Combinational signed multiply-accumulate for one lane: res = a*b + acc,
// either clamped to the ACC_W signed range or wrapped, with an out-of-range flag.
module vmx_sat_mac #(
  parameter int IN_W   = 16,
  parameter int ACC_W  = 32,
  parameter int SAT_EN = 1
) (
  input  logic signed [IN_W-1:0]  a,
  input  logic signed [IN_W-1:0]  b,
  input  logic signed [ACC_W-1:0] acc,
  output logic        [ACC_W-1:0] res,
  output logic                    ovf
);

  // One guard bit above the wider of product and accumulator keeps the sum exact.
  localparam int EXT_W = ((2 * IN_W > ACC_W) ? 2 * IN_W : ACC_W) + 1;

  localparam logic signed [EXT_W-1:0] MAX_V = {{(EXT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] MIN_V = {{(EXT_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  logic signed [EXT_W-1:0] a_x;
  logic signed [EXT_W-1:0] b_x;
  logic signed [EXT_W-1:0] acc_x;
  logic signed [EXT_W-1:0] full;
  logic                    too_big;
  logic                    too_small;

  assign a_x       = EXT_W'(a);
  assign b_x       = EXT_W'(b);
  assign acc_x     = EXT_W'(acc);
  assign full      = a_x * b_x + acc_x;
  assign too_big   = full > MAX_V;
  assign too_small = full < MIN_V;
  assign ovf       = too_big | too_small;

  always_comb begin
    res = full[ACC_W-1:0];
    if (SAT_EN != 0) begin
      if (too_big)        res = MAX_V[ACC_W-1:0];
      else if (too_small) res = MIN_V[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/vmx_pe_simd.sv
// Systolic PE: per-lane data*weight + sum_in with 1/2/4-lane split chosen per cycle,
// double-buffered weight loaded by a hop-counting token, sticky overflow flag.
module vmx_pe_simd
  import vmx_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SUM_W  = 2 * DATA_W,
  parameter int LC_W   = 8,
  parameter int SAT_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic              in_valid,
  input  logic [LC_W-1:0]   load_ctrl,
  input  logic              swap,
  input  logic              clr_ovf,
  input  logic [DATA_W-1:0] data,
  input  logic [SUM_W-1:0]  sum_in,
  output logic [1:0]        mode_pass,
  output logic              valid_pass,
  output logic [LC_W-1:0]   load_ctrl_pass,
  output logic              swap_pass,
  output logic [DATA_W-1:0] data_pass,
  output logic [SUM_W-1:0]  sum_out,
  output logic              ovf
);

  localparam int LW2 = lane_w(DATA_W, LANES_X2);
  localparam int LW4 = lane_w(DATA_W, LANES_X4);
  localparam int SW2 = lane_w(SUM_W, LANES_X2);
  localparam int SW4 = lane_w(SUM_W, LANES_X4);

  logic [DATA_W-1:0] shadow_w;
  logic [DATA_W-1:0] active_w;

  logic [SUM_W-1:0]  res_x1;
  logic [SUM_W-1:0]  res_x2;
  logic [SUM_W-1:0]  res_x4;
  logic              ovf_x1;
  logic [1:0]        ovf_x2;
  logic [3:0]        ovf_x4;
  logic [SUM_W-1:0]  mac_res;
  logic              mac_ovf;

  vmx_sat_mac #(.IN_W(DATA_W), .ACC_W(SUM_W), .SAT_EN(SAT_EN)) u_mac_x1 (
    .a(data), .b(active_w), .acc(sum_in), .res(res_x1), .ovf(ovf_x1)
  );

  for (genvar g = 0; g < LANES_X2; g++) begin : g_x2
    vmx_sat_mac #(.IN_W(LW2), .ACC_W(SW2), .SAT_EN(SAT_EN)) u_mac (
      .a(data[g*LW2 +: LW2]), .b(active_w[g*LW2 +: LW2]), .acc(sum_in[g*SW2 +: SW2]),
      .res(res_x2[g*SW2 +: SW2]), .ovf(ovf_x2[g])
    );
  end

  for (genvar g = 0; g < LANES_X4; g++) begin : g_x4
    vmx_sat_mac #(.IN_W(LW4), .ACC_W(SW4), .SAT_EN(SAT_EN)) u_mac (
      .a(data[g*LW4 +: LW4]), .b(active_w[g*LW4 +: LW4]), .acc(sum_in[g*SW4 +: SW4]),
      .res(res_x4[g*SW4 +: SW4]), .ovf(ovf_x4[g])
    );
  end

  // Mode 3 is not a distinct split; it behaves as the single full-width lane.
  always_comb begin
    mac_res = res_x1;
    mac_ovf = ovf_x1;
    case (mode)
      MODE_X2: begin
        mac_res = res_x2;
        mac_ovf = |ovf_x2;
      end
      MODE_X4: begin
        mac_res = res_x4;
        mac_ovf = |ovf_x4;
      end
      default: ;
    endcase
  end

  // Armed token with zero hops captures here and leaves disarmed, so it never re-arms downstream.
  logic            tok_is_armed;
  logic            tok_cnt_zero;
  logic            capture;
  logic [LC_W-1:0] lc_next;

  assign tok_is_armed = tok_armed(TOK_MAX_W'(load_ctrl), LC_W);
  assign tok_cnt_zero = (TOK_MAX_W'(load_ctrl) & tok_cnt_mask(LC_W)) == '0;
  assign capture      = tok_is_armed & tok_cnt_zero;

  always_comb begin
    lc_next = load_ctrl;
    if (capture)           lc_next = {1'b0, {(LC_W-1){1'b1}}};
    else if (tok_is_armed) lc_next = load_ctrl - LC_W'(1);
  end

  // in_valid qualifies data/sum_in in the same cycle; there is no backpressure, en stalls everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_w       <= '0;
      active_w       <= '0;
      mode_pass      <= '0;
      valid_pass     <= 1'b0;
      load_ctrl_pass <= '0;
      swap_pass      <= 1'b0;
      data_pass      <= '0;
      sum_out        <= '0;
      ovf            <= 1'b0;
    end else if (en) begin
      if (capture) shadow_w <= data;
      if (swap)    active_w <= shadow_w;
      mode_pass      <= mode;
      valid_pass     <= in_valid;
      load_ctrl_pass <= lc_next;
      swap_pass      <= swap;
      data_pass      <= data;
      sum_out        <= in_valid ? mac_res : '0;
      if (in_valid && mac_ovf) ovf <= 1'b1;
      else if (clr_ovf)        ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vmx_pe_simd.sv
// Bench for vmx_pe_simd: saturating and wrapping instances driven in parallel,
// checked against a lane-by-lane integer model of the PE.
module tb_vmx_pe_simd;

  logic        clk;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic        in_valid;
  logic [7:0]  load_ctrl;
  logic        swap;
  logic        clr_ovf;
  logic [15:0] data;
  logic [31:0] sum_in;

  logic [1:0]  s_mode_pass, w_mode_pass;
  logic        s_valid_pass, w_valid_pass;
  logic [7:0]  s_lc_pass, w_lc_pass;
  logic        s_swap_pass, w_swap_pass;
  logic [15:0] s_data_pass, w_data_pass;
  logic [31:0] s_sum_out, w_sum_out;
  logic        s_ovf, w_ovf;

  int checks;
  int failures;

  // model state and expected outputs
  logic [15:0] m_shadow, m_active;
  logic [1:0]  e_mode;
  logic        e_valid, e_swap, e_ovf_s, e_ovf_w;
  logic [7:0]  e_lc;
  logic [15:0] e_data;
  logic [31:0] e_sum_s, e_sum_w;

  vmx_pe_simd #(.DATA_W(16), .SUM_W(32), .LC_W(8), .SAT_EN(1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid),
    .load_ctrl(load_ctrl), .swap(swap), .clr_ovf(clr_ovf), .data(data), .sum_in(sum_in),
    .mode_pass(s_mode_pass), .valid_pass(s_valid_pass), .load_ctrl_pass(s_lc_pass),
    .swap_pass(s_swap_pass), .data_pass(s_data_pass), .sum_out(s_sum_out), .ovf(s_ovf)
  );

  vmx_pe_simd #(.DATA_W(16), .SUM_W(32), .LC_W(8), .SAT_EN(0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid),
    .load_ctrl(load_ctrl), .swap(swap), .clr_ovf(clr_ovf), .data(data), .sum_in(sum_in),
    .mode_pass(w_mode_pass), .valid_pass(w_valid_pass), .load_ctrl_pass(w_lc_pass),
    .swap_pass(w_swap_pass), .data_pass(w_data_pass), .sum_out(w_sum_out), .ovf(w_ovf)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lane-wise integer reference: split into signed lanes, multiply-add, clamp or wrap.
  function automatic void model_mac(input logic [1:0] md, input logic [15:0] d, input logic [15:0] w,
                                    input logic [31:0] s, input bit sat,
                                    output logic [31:0] res, output bit ov);
    int     lanes, lw, sw;
    longint dl, wl, sl, r, lo, hi, one;
    one   = 1;
    lanes = (md == 2'd1) ? 2 : (md == 2'd2) ? 4 : 1;
    lw    = 16 / lanes;
    sw    = 32 / lanes;
    res   = '0;
    ov    = 1'b0;
    for (int l = 0; l < lanes; l++) begin
      dl = (longint'(d) >> (l * lw)) & ((one << lw) - 1);
      wl = (longint'(w) >> (l * lw)) & ((one << lw) - 1);
      sl = (longint'(s) >> (l * sw)) & ((one << sw) - 1);
      if (dl >= (one << (lw - 1))) dl = dl - (one << lw);
      if (wl >= (one << (lw - 1))) wl = wl - (one << lw);
      if (sl >= (one << (sw - 1))) sl = sl - (one << sw);
      r  = dl * wl + sl;
      hi = (one << (sw - 1)) - 1;
      lo = -(one << (sw - 1));
      if (r > hi || r < lo) ov = 1'b1;
      if (sat && r > hi) r = hi;
      if (sat && r < lo) r = lo;
      r   = r & ((one << sw) - 1);
      res = res | (32'(r) << (l * sw));
    end
  endfunction

  // driver task: applies one cycle of inputs, advances the model, clocks, settles
  task automatic drive(input bit r, input bit e, input logic [1:0] md, input bit iv,
                       input logic [7:0] lc, input bit sw, input bit cl,
                       input logic [15:0] d, input logic [31:0] s);
    logic [31:0] rs, rw;
    bit          os, ow;
    logic [15:0] old_shadow;
    rst = r; en = e; mode = md; in_valid = iv; load_ctrl = lc;
    swap = sw; clr_ovf = cl; data = d; sum_in = s;
    if (r) begin
      m_shadow = '0; m_active = '0;
      e_mode = '0; e_valid = 0; e_swap = 0; e_lc = '0; e_data = '0;
      e_sum_s = '0; e_sum_w = '0; e_ovf_s = 0; e_ovf_w = 0;
    end else if (e) begin
      model_mac(md, d, m_active, s, 1'b1, rs, os);
      model_mac(md, d, m_active, s, 1'b0, rw, ow);
      e_sum_s = iv ? rs : '0;
      e_sum_w = iv ? rw : '0;
      e_ovf_s = (iv && os) ? 1'b1 : (cl ? 1'b0 : e_ovf_s);
      e_ovf_w = (iv && ow) ? 1'b1 : (cl ? 1'b0 : e_ovf_w);
      old_shadow = m_shadow;
      if (lc[7] && lc[6:0] == 7'd0) begin
        m_shadow = d;
        e_lc     = 8'h7F;
      end else if (lc[7]) begin
        e_lc = lc - 8'd1;
      end else begin
        e_lc = lc;
      end
      if (sw) m_active = old_shadow;
      e_mode = md; e_valid = iv; e_swap = sw; e_data = d;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 1, 2'd0, 0, 8'h00, 0, 0, 16'h0000, 32'h0);
  endtask

  task automatic test_reset();
    logic [31:0] s;
    drive(1, $urandom_range(0, 1), 2'($urandom), 1, 8'($urandom), 1, 0, 16'($urandom), $urandom);
    drive(1, 1, 2'($urandom), 1, 8'h80, 1, 0, 16'($urandom), $urandom);
    checks++;
    if ({s_mode_pass, s_valid_pass, s_lc_pass, s_swap_pass, s_data_pass, s_sum_out, s_ovf} !== '0) begin
      failures++;
      $display("FAIL reset_sat outputs not all zero: sum_out=%h lc=%h data=%h", s_sum_out, s_lc_pass, s_data_pass);
    end
    checks++;
    if ({w_mode_pass, w_valid_pass, w_lc_pass, w_swap_pass, w_data_pass, w_sum_out, w_ovf} !== '0) begin
      failures++;
      $display("FAIL reset_wrap outputs not all zero: sum_out=%h lc=%h data=%h", w_sum_out, w_lc_pass, w_data_pass);
    end
    s = $urandom;
    drive(0, 1, 2'd0, 1, 8'h00, 0, 0, 16'd5, s);
    checks++;
    if (s_sum_out !== s || w_sum_out !== s) begin
      failures++;
      $display("FAIL reset_zero_weight sum_out=%h/%h expected %h", s_sum_out, w_sum_out, s);
    end
  endtask

  task automatic test_load_swap();
    drive(0, 1, 2'd0, 0, 8'h80, 0, 0, 16'd3, 32'h0);
    checks++;
    if (s_lc_pass !== 8'h7F) begin
      failures++;
      $display("FAIL load_token_pass got %h expected 7f", s_lc_pass);
    end
    drive(0, 1, 2'd0, 0, 8'h00, 1, 0, 16'h0000, 32'h0);
    checks++;
    if (s_swap_pass !== 1'b1) begin
      failures++;
      $display("FAIL swap_pass got %b expected 1", s_swap_pass);
    end
    drive(0, 1, 2'd0, 1, 8'h00, 0, 0, 16'hFFFE, 32'd10);
    checks++;
    if (s_sum_out !== 32'd4 || w_sum_out !== 32'd4 || s_valid_pass !== 1'b1) begin
      failures++;
      $display("FAIL mode0_mac sum_out=%h/%h valid=%b expected 4/4 valid=1", s_sum_out, w_sum_out, s_valid_pass);
    end
  endtask

  task automatic test_token_walk();
    drive(0, 1, 2'd0, 0, 8'h82, 0, 0, 16'h1111, 32'h0);
    checks++;
    if (s_lc_pass !== 8'h81) begin
      failures++;
      $display("FAIL token_hop got %h expected 81", s_lc_pass);
    end
    drive(0, 1, 2'd0, 0, 8'h05, 0, 0, 16'h2222, 32'h0);
    checks++;
    if (s_lc_pass !== 8'h05) begin
      failures++;
      $display("FAIL token_disarmed got %h expected 05", s_lc_pass);
    end
    drive(0, 1, 2'd0, 0, 8'h00, 1, 0, 16'h0000, 32'h0);
    drive(0, 1, 2'd0, 1, 8'h00, 0, 0, 16'd1, 32'h0);
    checks++;
    if (s_sum_out !== 32'd3) begin
      failures++;
      $display("FAIL token_shadow_kept sum_out=%h expected 3", s_sum_out);
    end
  endtask

  task automatic test_mode1();
    drive(0, 1, 2'd0, 0, 8'h80, 0, 1, 16'h02FD, 32'h0);
    drive(0, 1, 2'd0, 0, 8'h00, 1, 0, 16'h0000, 32'h0);
    drive(0, 1, 2'd1, 1, 8'h00, 0, 0, 16'h0504, 32'h0001_0001);
    checks++;
    if (s_sum_out !== 32'h000B_FFF5 || w_sum_out !== 32'h000B_FFF5 || s_ovf !== 1'b0) begin
      failures++;
      $display("FAIL mode1_mac sum_out=%h/%h ovf=%b expected 000bfff5 ovf=0", s_sum_out, w_sum_out, s_ovf);
    end
    checks++;
    if (s_mode_pass !== 2'd1) begin
      failures++;
      $display("FAIL mode_pass got %0d expected 1", s_mode_pass);
    end
  endtask

  task automatic test_mode2_overflow();
    drive(0, 1, 2'd0, 0, 8'h80, 0, 0, 16'h7777, 32'h0);
    drive(0, 1, 2'd0, 0, 8'h00, 1, 0, 16'h0000, 32'h0);
    drive(0, 1, 2'd2, 1, 8'h00, 0, 0, 16'h7777, 32'h7F7F_7F7F);
    checks++;
    if (s_sum_out !== 32'h7F7F_7F7F || s_ovf !== 1'b1) begin
      failures++;
      $display("FAIL mode2_sat sum_out=%h ovf=%b expected 7f7f7f7f ovf=1", s_sum_out, s_ovf);
    end
    checks++;
    if (w_sum_out !== 32'hB0B0_B0B0 || w_ovf !== 1'b1) begin
      failures++;
      $display("FAIL mode2_wrap sum_out=%h ovf=%b expected b0b0b0b0 ovf=1", w_sum_out, w_ovf);
    end
    drive(0, 1, 2'd2, 0, 8'h00, 0, 0, 16'h0000, 32'h0);
    checks++;
    if (s_ovf !== 1'b1 || s_sum_out !== 32'h0) begin
      failures++;
      $display("FAIL ovf_sticky ovf=%b sum_out=%h expected ovf=1 sum_out=0", s_ovf, s_sum_out);
    end
    drive(0, 1, 2'd2, 0, 8'h00, 0, 1, 16'h7777, 32'h7F7F_7F7F);
    checks++;
    if (s_ovf !== 1'b0 || w_ovf !== 1'b0 || s_sum_out !== 32'h0) begin
      failures++;
      $display("FAIL ovf_clear ovf=%b/%b sum_out=%h expected 0/0 0", s_ovf, w_ovf, s_sum_out);
    end
    drive(0, 1, 2'd2, 1, 8'h00, 0, 1, 16'h7777, 32'h7F7F_7F7F);
    checks++;
    if (s_ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set_beats_clear ovf=%b expected 1", s_ovf);
    end
  endtask

  task automatic test_capture_swap();
    drive(0, 1, 2'd0, 0, 8'h80, 0, 1, 16'd3, 32'h0);
    drive(0, 1, 2'd0, 0, 8'h80, 1, 0, 16'd9, 32'h0);
    drive(0, 1, 2'd0, 1, 8'h00, 0, 0, 16'd1, 32'h0);
    checks++;
    if (s_sum_out !== 32'd3) begin
      failures++;
      $display("FAIL capture_swap_old active gave %h expected 3", s_sum_out);
    end
    drive(0, 1, 2'd0, 0, 8'h00, 1, 0, 16'h0000, 32'h0);
    drive(0, 1, 2'd0, 1, 8'h00, 0, 0, 16'd1, 32'h0);
    checks++;
    if (s_sum_out !== 32'd9) begin
      failures++;
      $display("FAIL capture_swap_new active gave %h expected 9", s_sum_out);
    end
  endtask

  task automatic test_stall();
    logic [31:0] hold_sum;
    logic [15:0] hold_data;
    logic [7:0]  hold_lc;
    drive(0, 1, 2'd1, 1, 8'h83, 1, 0, 16'h1357, 32'h0ABC_0DEF);
    hold_sum = e_sum_s; hold_data = e_data; hold_lc = e_lc;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 2'($urandom), 1, 8'h80, 1, 1, 16'($urandom), $urandom);
      checks++;
      if (s_sum_out !== hold_sum || s_data_pass !== hold_data || s_lc_pass !== hold_lc ||
          s_valid_pass !== 1'b1 || s_swap_pass !== 1'b1 || s_mode_pass !== 2'd1) begin
        failures++;
        $display("FAIL stall_hold cycle %0d sum=%h data=%h lc=%h expected %h %h %h",
                 i, s_sum_out, s_data_pass, s_lc_pass, hold_sum, hold_data, hold_lc);
      end
    end
    drive(0, 1, 2'd0, 1, 8'h00, 0, 0, 16'd2, 32'd1);
    checks++;
    if (s_sum_out !== e_sum_s) begin
      failures++;
      $display("FAIL stall_weights_held sum_out=%h expected %h", s_sum_out, e_sum_s);
    end
  endtask

  task automatic test_reset_mid_load();
    drive(0, 1, 2'd0, 0, 8'h80, 0, 0, 16'h00AA, 32'h0);
    drive(1, 1, 2'd0, 0, 8'h80, 1, 0, 16'h1234, 32'h0);
    drive(0, 1, 2'd0, 0, 8'h00, 1, 0, 16'h0000, 32'h0);
    drive(0, 1, 2'd0, 1, 8'h00, 0, 0, 16'd1, 32'd7);
    checks++;
    if (s_sum_out !== 32'd7 || w_sum_out !== 32'd7) begin
      failures++;
      $display("FAIL reset_mid_load sum_out=%h/%h expected 7", s_sum_out, w_sum_out);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) != 0), 2'($urandom),
            $urandom_range(0, 3) != 0,
            ($urandom_range(0, 2) == 0) ? 8'h80 : 8'($urandom),
            $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
            16'($urandom), $urandom);
      checks++;
      if (s_sum_out !== e_sum_s || s_ovf !== e_ovf_s) begin
        failures++;
        $display("FAIL rand_sat #%0d sum_out=%h ovf=%b expected %h %b", i, s_sum_out, s_ovf, e_sum_s, e_ovf_s);
      end
      checks++;
      if (w_sum_out !== e_sum_w || w_ovf !== e_ovf_w) begin
        failures++;
        $display("FAIL rand_wrap #%0d sum_out=%h ovf=%b expected %h %b", i, w_sum_out, w_ovf, e_sum_w, e_ovf_w);
      end
      checks++;
      if (s_lc_pass !== e_lc || s_data_pass !== e_data || s_mode_pass !== e_mode ||
          s_valid_pass !== e_valid || s_swap_pass !== e_swap) begin
        failures++;
        $display("FAIL rand_pass #%0d lc=%h data=%h mode=%0d v=%b sw=%b expected %h %h %0d %b %b",
                 i, s_lc_pass, s_data_pass, s_mode_pass, s_valid_pass, s_swap_pass,
                 e_lc, e_data, e_mode, e_valid, e_swap);
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    m_shadow = '0; m_active = '0;
    e_mode = '0; e_valid = 0; e_swap = 0; e_lc = '0; e_data = '0;
    e_sum_s = '0; e_sum_w = '0; e_ovf_s = 0; e_ovf_w = 0;
    rst = 1; en = 1; mode = '0; in_valid = 0; load_ctrl = '0;
    swap = 0; clr_ovf = 0; data = '0; sum_in = '0;
    #1;
    test_reset();
    test_load_swap();
    test_token_walk();
    test_mode1();
    test_mode2_overflow();
    test_capture_swap();
    test_stall();
    test_reset_mid_load();
    idle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
